// File: rtl/clock_display_scan_if.sv
// Bundle between the HH:MM:SS counter, the scan driver and the display.
//   sec, min, hrs    : binary time fields from the counter
//   an               : digit enables, active-low, an[0] = rightmost digit
//   seg              : segments {g,f,e,d,c,b,a}, active-low
//   dp               : decimal point (field separator), active-low
//   frame_start      : one-cycle pulse when a new snapshot is taken
// master = time source / observer side, slave = scan driver side.
interface clock_display_scan_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hrs;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    modport master (output sec, min, hrs, input an, seg, dp, frame_start);
    modport slave  (input sec, min, hrs, output an, seg, dp, frame_start);
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment driver for an HH:MM:SS counter.
// Captures a coherent snapshot once per frame, splits each field into
// tens/ones and scans one digit per REFRESH_DIV clocks.
//   clk    : clock
//   reset  : asynchronous, active-high
//   disp   : slave side of clock_display_scan_if (time in, display out)
// Parameters:
//   REFRESH_DIV   : clocks each digit is lit (>= 2)
//   BLANK_LEADING : blank the hours-tens digit when it is 0
module clock_display_scan #(
    parameter int REFRESH_DIV   = 1000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_display_scan_if.slave  disp
);

    localparam int             PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_TC  = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_DASH  = 7'b0111111;
    localparam logic [6:0]     SEG_BLANK = 7'b1111111;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    snap_sec_q, snap_sec_d;
    logic [5:0]    snap_min_q, snap_min_d;
    logic [4:0]    snap_hrs_q, snap_hrs_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_start_q, frame_start_d;

    logic          tick;
    logic [7:0]    sec_split, min_split, hrs_split;
    logic          sec_bad, min_bad, hrs_bad;

    // {tens, ones} for values up to 63; a compare chain is enough since
    // valid fields never exceed 59.
    function automatic logic [7:0] split(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] base;
        if      (v >= 6'd60) begin t = 4'd6; base = 6'd60; end
        else if (v >= 6'd50) begin t = 4'd5; base = 6'd50; end
        else if (v >= 6'd40) begin t = 4'd4; base = 6'd40; end
        else if (v >= 6'd30) begin t = 4'd3; base = 6'd30; end
        else if (v >= 6'd20) begin t = 4'd2; base = 6'd20; end
        else if (v >= 6'd10) begin t = 4'd1; base = 6'd10; end
        else                 begin t = 4'd0; base = 6'd0;  end
        return {t, 4'(v - base)};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign tick = (presc_q == PRESC_TC);

    always_comb begin
        presc_d       = tick ? '0 : presc_q + 1'b1;
        idx_d         = idx_q;
        snap_sec_d    = snap_sec_q;
        snap_min_d    = snap_min_q;
        snap_hrs_d    = snap_hrs_q;
        frame_start_d = 1'b0;

        if (tick) begin
            if (idx_q == 3'd5) begin
                // Snapshot and wrap share one edge so a frame is never torn.
                idx_d         = 3'd0;
                snap_sec_d    = disp.sec;
                snap_min_d    = disp.min;
                snap_hrs_d    = disp.hrs;
                frame_start_d = 1'b1;
            end else if (idx_q > 3'd5) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        sec_split = split(snap_sec_q);
        min_split = split(snap_min_q);
        hrs_split = split({1'b0, snap_hrs_q});
        sec_bad   = (snap_sec_q > 6'd59);
        min_bad   = (snap_min_q > 6'd59);
        hrs_bad   = (snap_hrs_q > 5'd23);

        an_d  = 6'b111111;
        seg_d = SEG_BLANK;
        case (idx_q)
            3'd0: begin an_d = 6'b111110; seg_d = sec_bad ? SEG_DASH : seg7(sec_split[3:0]); end
            3'd1: begin an_d = 6'b111101; seg_d = sec_bad ? SEG_DASH : seg7(sec_split[7:4]); end
            3'd2: begin an_d = 6'b111011; seg_d = min_bad ? SEG_DASH : seg7(min_split[3:0]); end
            3'd3: begin an_d = 6'b110111; seg_d = min_bad ? SEG_DASH : seg7(min_split[7:4]); end
            3'd4: begin an_d = 6'b101111; seg_d = hrs_bad ? SEG_DASH : seg7(hrs_split[3:0]); end
            3'd5: begin
                an_d = 6'b011111;
                if (hrs_bad)
                    seg_d = SEG_DASH;
                else if (BLANK_LEADING && (hrs_split[7:4] == 4'd0))
                    seg_d = SEG_BLANK;
                else
                    seg_d = seg7(hrs_split[7:4]);
            end
            default: begin an_d = 6'b111111; seg_d = SEG_BLANK; end
        endcase

        // Separator lit on even seconds only, between the fields.
        dp_d = !(((idx_q == 3'd2) || (idx_q == 3'd4)) && !sec_bad && !snap_sec_q[0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= 3'd0;
            snap_sec_q    <= 6'd0;
            snap_min_q    <= 6'd0;
            snap_hrs_q    <= 5'd0;
            an_q          <= 6'b111111;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            snap_sec_q    <= snap_sec_d;
            snap_min_q    <= snap_min_d;
            snap_hrs_q    <= snap_hrs_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign disp.an          = an_q;
    assign disp.seg         = seg_q;
    assign disp.dp          = dp_q;
    assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_display_scan.sv
module tb_clock_display_scan;
    localparam int R     = 4;
    localparam int FRAME = 6 * R;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] sec_in = 6'd0;
    logic [5:0] min_in = 6'd0;
    logic [4:0] hrs_in = 5'd0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clock_display_scan_if if0 ();
    clock_display_scan_if if1 ();

    assign if0.sec = sec_in;
    assign if0.min = min_in;
    assign if0.hrs = hrs_in;
    assign if1.sec = sec_in;
    assign if1.min = min_in;
    assign if1.hrs = hrs_in;

    clock_display_scan #(.REFRESH_DIV(R), .BLANK_LEADING(1'b1)) u0 (
        .clk(clk), .reset(reset), .disp(if0));
    clock_display_scan #(.REFRESH_DIV(R), .BLANK_LEADING(1'b0)) u1 (
        .clk(clk), .reset(reset), .disp(if1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segments for digit d of a display of h:m:s.
    function automatic logic [6:0] exp_seg(input int d, input int s, input int m,
                                           input int h, input bit blank);
        int v, mx;
        if (d / 2 == 0)      begin v = s; mx = 59; end
        else if (d / 2 == 1) begin v = m; mx = 59; end
        else                 begin v = h; mx = 23; end
        if (v > mx) return 7'b0111111;
        if (d % 2 == 1) begin
            if (blank && d == 5 && v / 10 == 0) return 7'b1111111;
            return code(v / 10);
        end
        return code(v % 10);
    endfunction

    // Reference model: t counts clock edges since reset release.
    int t, ms, mm, mh, ps, pm, ph, d;
    bit prst;
    logic [5:0] ea;
    logic       edp;
    initial begin
        t = 0; ms = 0; mm = 0; mh = 0;
        forever begin
            @(posedge clk);
            prst = reset; ps = sec_in; pm = min_in; ph = hrs_in;
            @(negedge clk);
            if (reset || prst) begin
                t = 0; ms = 0; mm = 0; mh = 0;
                chk("rst.an0",  if0.an, 6'h3F);
                chk("rst.seg0", if0.seg, 7'h7F);
                chk("rst.dp0",  if0.dp, 1'b1);
                chk("rst.fs0",  if0.frame_start, 1'b0);
                chk("rst.an1",  if1.an, 6'h3F);
                chk("rst.seg1", if1.seg, 7'h7F);
            end else begin
                t++;
                d   = ((t - 1) / R) % 6;
                ea  = 6'h3F ^ (6'h01 << d);
                edp = ((d == 2 || d == 4) && ms <= 59 && ms % 2 == 0) ? 1'b0 : 1'b1;
                chk("mdl.an0",  if0.an, ea);
                chk("mdl.seg0", if0.seg, exp_seg(d, ms, mm, mh, 1'b1));
                chk("mdl.dp0",  if0.dp, edp);
                chk("mdl.fs0",  if0.frame_start, (t % FRAME == 0));
                chk("mdl.an1",  if1.an, ea);
                chk("mdl.seg1", if1.seg, exp_seg(d, ms, mm, mh, 1'b0));
                chk("mdl.dp1",  if1.dp, edp);
                chk("mdl.fs1",  if1.frame_start, (t % FRAME == 0));
                if (t % FRAME == 0) begin ms = ps; mm = pm; mh = ph; end
            end
        end
    end

    int e;
    task automatic go(input int target);
        while (e < target) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    initial begin
        e = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        e = 0;

        go(1);   chk("first.an", if0.an, 6'b111110); chk("first.seg", if0.seg, 7'b1000000);
        go(5);   chk("dig1.an", if0.an, 6'b111101);
        go(10);  hrs_in = 5'd23; min_in = 6'd45; sec_in = 6'd8;
        go(21);  chk("dig5.an", if0.an, 6'b011111);
                 chk("blank.on", if0.seg, 7'b1111111);
                 chk("blank.off0", if1.seg, 7'b1000000);
        go(23);  chk("fs.pre", if0.frame_start, 1'b0);
        go(24);  chk("fs.24", if0.frame_start, 1'b1);
        go(25);  chk("fs.post", if0.frame_start, 1'b0); chk("dec.s1", if0.seg, 7'b0000000);
        go(29);  chk("dec.s10", if0.seg, 7'b1000000);
        go(30);  min_in = 6'd46;
        go(33);  chk("coh.m1", if0.seg, 7'b0010010); chk("dec.dp2", if0.dp, 1'b0);
        go(37);  chk("dec.m10", if0.seg, 7'b0011001);
        go(41);  chk("dec.h1", if0.seg, 7'b0110000); chk("dec.dp4", if0.dp, 1'b0);
        go(45);  chk("dec.h10", if0.seg, 7'b0100100);
        go(50);  sec_in = 6'd61; hrs_in = 5'd24;
        go(57);  chk("coh.m2", if0.seg, 7'b0000010);
        go(73);  chk("oor.s1", if0.seg, 7'b0111111);
        go(75);  hrs_in = 5'd5; sec_in = 6'd7;
        go(81);  chk("oor.m1", if0.seg, 7'b0000010); chk("oor.dp", if0.dp, 1'b1);
        go(89);  chk("oor.h1", if0.seg, 7'b0111111);
        go(105); chk("odd.dp", if1.dp, 1'b1);
        go(117); chk("nob.h10", if1.seg, 7'b1000000); chk("blk.h10", if0.seg, 7'b1111111);
        go(134); reset = 1'b1;
        #1;      chk("arst.an", if0.an, 6'h3F); chk("arst.seg", if0.seg, 7'h7F);
                 chk("arst.dp", if0.dp, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        e = 0;
        go(1);   chk("rel.an", if0.an, 6'b111110); chk("rel.seg", if0.seg, 7'b1000000);
        go(9);   chk("rel.m1", if0.seg, 7'b1000000);
        go(FRAME + 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed six-digit seven-segment driver for the HH:MM:SS time-of-day counter. It sits directly downstream of that counter and takes its binary `sec`/`min`/`hrs` outputs. Once per frame it captures a coherent snapshot, splits each field into tens/ones, and scans the digits one at a time onto shared active-low segment lines.

## Interface
- `REFRESH_DIV`, default 1000: clk cycles each digit stays lit. Legal values are 2 or more.
- `BLANK_LEADING`, default 1: when 1, the hours-tens digit is blanked if it is 0.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `sec` in 6: seconds, binary, 0..59 valid.
- `min` in 6: minutes, binary, 0..59 valid.
- `hrs` in 5: hours, binary, 0..23 valid.
- `an` out 6: digit enables, active-low, one-hot-low. `an[0]` is the rightmost digit.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low, used as the field separator.
- `frame_start` out 1: one-cycle pulse when a new snapshot is taken.

## Operation
- **Prescaler:** counts 0..`REFRESH_DIV`-1 and wraps. Its terminal count is the *tick*.
- **Digit index:** 3 bits, 0..5.
  - Advances on each tick and wraps from 5 to 0.
  - Values 6 and 7 are unreachable. If ever reached, the index goes to 0 on the next tick.
- **Digit map:**
  - 0 = sec ones, 1 = sec tens
  - 2 = min ones, 3 = min tens
  - 4 = hrs ones, 5 = hrs tens
- **Snapshot:**
  - On the tick where the index is 5, `sec`/`min`/`hrs` are registered into snapshot registers, on the same edge the index wraps to 0.
  - Input changes at any other time have no effect until the next frame. This prevents torn displays.
- **Split:**
  - tens = value/10 and ones = value%10, computed from the snapshot.
  - Values are ≤59, so a compare chain against 10/20/30/40/50 is sufficient. No divider.
- **Range check:**
  - A snapshot field out of range (sec or min >59, hrs >23) shows a dash (`0111111`) on both digits of that field.
  - Other fields are unaffected.
- **Segment codes (`{g..a}`):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- **Blanking:** when `BLANK_LEADING`=1 and the hours tens digit is 0 (not out of range), digit 5 shows blank. `an[5]` still asserts for that slot.
- **Separator:**
  - `dp` is 0 on digits 2 and 4 when snapshot `sec[0]`==0, so the separator blinks at 0.5 Hz with a 1 Hz seconds source.
  - Otherwise `dp` is 1. An out-of-range sec field forces `dp`=1.

## Timing
- **Reset values:** prescaler 0, index 0, snapshot 0, `an`=111111, `seg`=1111111, `dp`=1, `frame_start`=0.
- **Output latency:**
  - `an`, `seg` and `dp` are registered from the index and snapshot, so they lag the index by exactly one clk.
  - `an` and `seg` always change on the same edge, so the enable and data of different digits never mix.
- **First edge after reset release:** `an`=111110 and `seg`=1000000 (digit 0 of snapshot 0).
- **Slot length:** each digit is lit for exactly `REFRESH_DIV` cycles. A frame is 6×`REFRESH_DIV` cycles.
- **`frame_start`:** registered. It is high for exactly the one cycle after the snapshot edge, coincident with the index first reading 0.
  - First pulse: 6×`REFRESH_DIV` cycles after reset release.
- **Reset mid-frame:** everything returns to reset values immediately, asynchronously. The snapshot reverts to 0 and scanning restarts at digit 0.
- **Input change on the snapshot edge:** the value present at that edge is captured.

## Test plan
- **Reset/first frame:** `REFRESH_DIV`=4, `sec`=0, `min`=0, `hrs`=0, `BLANK_LEADING`=1, release reset.
  - `an` steps 111110→111101→…→011111, 4 cycles each.
  - `seg` is 1000000 on digits 0–4 and 1111111 on digit 5.
  - `frame_start` pulses at cycle 24.
- **Field decode:** inputs hrs=23, min=45, sec=08, wait one frame.
  - Digits 0..5 show 8, 0, 5, 4, 3, 2, i.e. `seg` 0000000, 1000000, 0010010, 0011001, 0110000, 0100100.
  - `dp`=0 on digits 2 and 4 (sec even).
- **Snapshot coherence:** change `min` from 45 to 46 mid-frame while digit 1 is lit.
  - Digit 2 still shows 5 in the current frame and shows 6 only after the next `frame_start`.
- **Out-of-range:** inputs sec=61, hrs=24.
  - Digits 0, 1, 4 and 5 show 0111111; min digits decode normally.
  - `dp`=1 on all digits.
- **Blanking off / odd seconds:** `BLANK_LEADING`=0, hrs=5, sec=7.
  - Digit 5 shows 1000000.
  - `dp` stays 1 on every digit for the whole frame.
- **Async reset mid-scan:** assert `reset` while digit 3 is lit, between clock edges.
  - `an`=111111 and `seg`=1111111 immediately.
  - After release, scanning restarts at digit 0 with zeros displayed.
